lal_seq: RTL and testbench

Sequencer stage feeding the `lal` control decoder. It owns the 9-bit state chain that drives `lal` inputs s..a0 (s = bit 0, a0 = bit 8) as a registered up-counter with hold and clear. Each cycle it captures the 19 decoded `lal` outputs (b0..t0) into a single-entry output register and presents them downstream under a valid/ready handshake. It turns the combinational decoder into a stepped, back-pressurable control source.

---
 rtl/lal_seq.sv | 88 ++++++++
 tb/tb_lal_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lal_seq.sv
// Stepped sequencer for the lal decoder: counts the s..a0 state chain and captures lal outputs
// into a valid/ready output register. Optional out_par port enabled by LAL_SEQ_PARITY_EN.
module lal_seq #(
  parameter int unsigned          CNT_W = 9,
  parameter int unsigned          OUT_W = 19,
  parameter logic [CNT_W-1:0]     TERM  = 9'h1FF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  input  logic [OUT_W-1:0] lal_out,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
`ifdef LAL_SEQ_PARITY_EN
  ,
  output logic             out_par
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, STALL, DONE} state_t;

  state_t state, state_nx;
  logic   step, xfer, at_term;

  assign at_term = (cnt == TERM);
  assign xfer    = out_valid && out_ready;
  // A capture needs the output slot free or being emptied on this same edge.
  assign step    = (state == RUN) && !hold && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN: begin
        if (step && at_term)                         state_nx = DONE;
        else if (!hold && out_valid && !out_ready)   state_nx = STALL;
      end
      STALL: if (out_ready) state_nx = RUN;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clr) state_nx = IDLE;
  end

  always_comb begin
    busy = (state == RUN) || (state == STALL);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
`ifdef LAL_SEQ_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else if (clr) begin
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (step) begin
        out_data  <= lal_out;
        out_valid <= 1'b1;
`ifdef LAL_SEQ_PARITY_EN
        out_par   <= ^lal_out;
`endif
        if (!at_term) cnt <= cnt + CNT_W'(1);
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      // cnt sits at TERM for the DONE cycle, then rewinds so IDLE always presents 0.
      if (state == DONE) cnt <= '0;
    end
  end

endmodule

// File: tb/tb_lal_seq.sv
// Scoreboard bench for lal_seq: stimulus queues expected captures, a negedge monitor
// pops them on every handshake and checks stall stability and done pulses.
module tb_lal_seq;

  localparam logic [8:0] TERM = 9'h0A3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, hold = 1'b0, clr = 1'b0, out_ready = 1'b1;
  logic [8:0]  cnt;
  logic [18:0] lal_out, out_data;
  logic        out_valid, busy, done;
  logic        force_en = 1'b0;
  logic [18:0] force_val = '0;
`ifdef LAL_SEQ_PARITY_EN
  logic        out_par;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [18:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [18:0] stall_data = '0;

  lal_seq #(.CNT_W(9), .OUT_W(19), .TERM(TERM)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .clr(clr),
    .cnt(cnt), .lal_out(lal_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
`ifdef LAL_SEQ_PARITY_EN
    , .out_par(out_par)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for the lal decoder: a fixed combinational function of the state chain.
  function automatic logic [18:0] lal_f(input logic [8:0] c);
    return {c[7:0] ^ 8'hA5, ~c, c[8], c[0] ^ c[3]};
  endfunction

  assign lal_out = force_en ? force_val : lal_f(cnt);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) chk("stall_stable", out_data, stall_data);
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("sb_data", out_data, exp_q.pop_front());
      end
      if (done) done_cnt++;
    end
  end

  task automatic begin_run();
    done_cnt = 0;
    for (int i = 0; i <= int'(TERM); i++) exp_q.push_back(lal_f(9'(i)));
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_cnt(input logic [8:0] tgt);
    int unsigned k = 0;
    while (cnt !== tgt && k < 400) begin
      tick();
      k++;
    end
    chk("wait_cnt", cnt, tgt);
  endtask

  task automatic finish_run();
    int unsigned k = 0;
    while (!done && k < 400) begin
      tick();
      k++;
    end
    chk("done_seen", done, 1);
    tick();
    chk("done_fall", done, 0);
    chk("busy_after", busy, 0);
    chk("done_once", done_cnt, 1);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic full_run();
    int unsigned cyc;
    begin_run();
    chk("start_busy", busy, 1);
    chk("start_cnt", cnt, 0);
    chk("start_valid", out_valid, 0);
    tick();
    cyc = 1;
    chk("first_valid", out_valid, 1);
    chk("first_data", out_data, lal_f(9'd0));
    chk("first_cnt", cnt, 1);
    while (!done && cyc < 400) begin
      tick();
      cyc++;
    end
    chk("run_len", cyc, 32'(TERM) + 1);
    chk("term_cnt", cnt, TERM);
    tick();
    chk("done_fall", done, 0);
    chk("busy_after", busy, 0);
    chk("done_once", done_cnt, 1);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_cnt", cnt, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #10 rst = 1'b0;
    tick();

    // Full run at full throughput
    full_run();
    tick();

    // Stall: consumer withholds ready for three cycles after the first capture
    begin_run();
    tick();
    chk("stl_first", out_valid, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_cnt", cnt, 1);
      chk("stl_valid", out_valid, 1);
      chk("stl_busy", busy, 1);
    end
    out_ready = 1'b1;
    tick();
    chk("stl_exit_valid", out_valid, 0);
    chk("stl_exit_cnt", cnt, 1);
    tick();
    chk("stl_next_valid", out_valid, 1);
    chk("stl_next_data", out_data, lal_f(9'd1));
    chk("stl_next_cnt", cnt, 2);
    finish_run();
    tick();

    // Hold for three cycles once cnt reaches 2
    begin_run();
    tick();
    tick();
    chk("hld_pre_cnt", cnt, 2);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hld_cnt", cnt, 2);
      if (i > 0) chk("hld_valid", out_valid, 0);
    end
    hold = 1'b0;
    tick();
    chk("hld_res_valid", out_valid, 1);
    chk("hld_res_data", out_data, lal_f(9'd2));
    chk("hld_res_cnt", cnt, 3);
    finish_run();
    tick();

    // Clear with a capture pending
    begin_run();
    wait_cnt(9'd5);
    chk("clr_pre_valid", out_valid, 1);
    chk("clr_pre_data", out_data, lal_f(9'd4));
    out_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
    chk("clr_cnt", cnt, 0);
    chk("clr_valid", out_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    out_ready = 1'b1;
    tick();
    tick();
    chk("clr_no_done", done_cnt, 0);
    chk("clr_idle_busy", busy, 0);

    // Asynchronous reset mid-run, then a fresh run from 0
    begin_run();
    wait_cnt(9'h0A0);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_cnt", cnt, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", out_data, 0);
    #1 rst = 1'b0;
    tick();
    full_run();
    tick();

`ifdef LAL_SEQ_PARITY_EN
    force_en = 1'b1;
    force_val = 19'h00007;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("par_data7", out_data, 19'h00007);
    chk("par_odd", out_par, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    force_val = 19'h00003;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("par_data3", out_data, 19'h00003);
    chk("par_even", out_par, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    force_en = 1'b0;
    out_ready = 1'b1;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
